// File: rtl/awg_param_ctrl.sv
// rtl/awg_param_ctrl.sv - pushbutton-driven parameter registers for the waveform generators
module awg_param_ctrl #(
  parameter int unsigned DEBOUNCE_CYCLES = 500000,
  parameter int unsigned REPEAT_DELAY    = 25000000,
  parameter int unsigned REPEAT_PERIOD   = 5000000,
  parameter int unsigned FREQ_STEP       = 16,
  parameter int unsigned PHASE_STEP      = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        btn_mode,
  input  logic        btn_up,
  input  logic        btn_down,
  output logic [11:0] state_freq,
  output logic [2:0]  state_amp,
  output logic [7:0]  state_phase,
  output logic [1:0]  wave_sel,
  output logic [3:0]  wave_en,
  output logic [1:0]  edit_sel
);

  localparam int DBW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int RPW = $clog2(REPEAT_DELAY + 1);
  localparam logic [DBW-1:0] DB_LAST   = DBW'(DEBOUNCE_CYCLES - 1);
  localparam logic [RPW-1:0] RP_FIRE   = RPW'(REPEAT_DELAY - 1);
  localparam logic [RPW-1:0] RP_RELOAD = RPW'(REPEAT_DELAY - REPEAT_PERIOD);
  localparam logic [12:0]    F_STEP    = 13'(FREQ_STEP);
  localparam logic [7:0]     P_STEP    = 8'(PHASE_STEP);

  typedef enum logic [1:0] {F_FREQ = 2'd0, F_AMP = 2'd1, F_PHASE = 2'd2, F_WAVE = 2'd3} field_e;

  // Button index: 0 = mode, 1 = up, 2 = down.
  logic [2:0]     btn_raw;
  logic [2:0]     sync1_q, sync2_q, deb_q, deb_prev_q, press;
  logic [DBW-1:0] db_cnt_q [3];

  assign btn_raw = {btn_down, btn_up, btn_mode};
  assign press   = deb_q & ~deb_prev_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q    <= '0;
      sync2_q    <= '0;
      deb_q      <= '0;
      deb_prev_q <= '0;
      for (int i = 0; i < 3; i++) db_cnt_q[i] <= '0;
    end else begin
      sync1_q    <= btn_raw;
      sync2_q    <= sync1_q;
      deb_prev_q <= deb_q;
      for (int i = 0; i < 3; i++) begin
        if (sync2_q[i] == deb_q[i]) begin
          db_cnt_q[i] <= '0;
        end else if (db_cnt_q[i] == DB_LAST) begin
          deb_q[i]    <= sync2_q[i];
          db_cnt_q[i] <= '0;
        end else begin
          db_cnt_q[i] <= db_cnt_q[i] + DBW'(1);
        end
      end
    end
  end

  logic mode_p, up_p, dn_p;
  assign mode_p = press[0];
  assign up_p   = press[1];
  assign dn_p   = press[2];

  field_e field_q, field_d;
  logic   rep_field;

  always_ff @(posedge clk) begin
    if (rst) field_q <= F_FREQ;
    else     field_q <= field_d;
  end

  always_comb begin
    field_d = field_q;
    if (mode_p) field_d = field_e'(field_q + 2'd1);
  end

  always_comb begin
    edit_sel  = field_q;
    rep_field = (field_q == F_FREQ) || (field_q == F_PHASE);
  end

  // Once both directions are held together, repeat stays off until both are released.
  logic           block_q, block_d, rep_run, rep_fire;
  logic [RPW-1:0] rep_cnt_q, rep_cnt_d;

  always_comb begin
    block_d  = (block_q | (deb_q[1] & deb_q[2])) & (deb_q[1] | deb_q[2]);
    rep_run  = (deb_q[1] ^ deb_q[2]) & ~block_q & rep_field;
    rep_fire = rep_run && (rep_cnt_q == RP_FIRE);
    if (!rep_run || up_p || dn_p || mode_p) rep_cnt_d = '0;
    else if (rep_fire)                      rep_cnt_d = RP_RELOAD;
    else                                    rep_cnt_d = rep_cnt_q + RPW'(1);
  end

  logic up_ev, dn_ev, step_up, step_dn;
  assign up_ev   = (up_p | (rep_fire & deb_q[1])) & ~mode_p;
  assign dn_ev   = (dn_p | (rep_fire & deb_q[2])) & ~mode_p;
  assign step_up = up_ev & ~dn_ev;
  assign step_dn = dn_ev & ~up_ev;

  logic [11:0] freq_q, freq_d;
  logic [2:0]  amp_q, amp_d;
  logic [7:0]  phase_q, phase_d;
  logic [1:0]  wave_q, wave_d;
  logic [3:0]  wave_en_q, wave_en_d;
  logic [12:0] freq_sum, freq_dif;

  always_comb begin
    freq_d   = freq_q;
    amp_d    = amp_q;
    phase_d  = phase_q;
    wave_d   = wave_q;
    freq_sum = {1'b0, freq_q} + F_STEP;
    freq_dif = {1'b0, freq_q} - F_STEP;
    case (field_q)
      F_FREQ: begin
        if (step_up) freq_d = (freq_sum > 13'd4095) ? 12'd4095 : freq_sum[11:0];
        if (step_dn) freq_d = (freq_dif[12] || freq_dif == 13'd0) ? 12'd1 : freq_dif[11:0];
      end
      F_AMP: begin
        if (step_up && amp_q != 3'd7) amp_d = amp_q + 3'd1;
        if (step_dn && amp_q > 3'd1)  amp_d = amp_q - 3'd1;
      end
      F_PHASE: begin
        if (step_up) phase_d = phase_q + P_STEP;
        if (step_dn) phase_d = phase_q - P_STEP;
      end
      default: begin
        if (step_up) wave_d = wave_q + 2'd1;
        if (step_dn) wave_d = wave_q - 2'd1;
      end
    endcase
    wave_en_d = 4'b0001 << wave_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      freq_q    <= 12'd16;
      amp_q     <= 3'd1;
      phase_q   <= 8'd0;
      wave_q    <= 2'd0;
      wave_en_q <= 4'b0001;
      block_q   <= 1'b0;
      rep_cnt_q <= '0;
    end else begin
      freq_q    <= freq_d;
      amp_q     <= amp_d;
      phase_q   <= phase_d;
      wave_q    <= wave_d;
      wave_en_q <= wave_en_d;
      block_q   <= block_d;
      rep_cnt_q <= rep_cnt_d;
    end
  end

  assign state_freq  = freq_q;
  assign state_amp   = amp_q;
  assign state_phase = phase_q;
  assign wave_sel    = wave_q;
  assign wave_en     = wave_en_q;

endmodule
